// File: rtl/entropy_src_wm_pkg.sv
// Shared widths, reset constants and channel state type for the entropy_src watermark bank.
package entropy_src_wm_pkg;

    localparam int WmRegWidthDefault = 16;
    localparam int WmCntWidthDefault = 8;

    localparam logic [WmRegWidthDefault-1:0] WmHiRstDefault = {WmRegWidthDefault{1'b0}};
    localparam logic [WmRegWidthDefault-1:0] WmLoRstDefault = {WmRegWidthDefault{1'b1}};

    typedef struct packed {
        logic [WmRegWidthDefault-1:0] hi;
        logic [WmRegWidthDefault-1:0] lo;
        logic [WmCntWidthDefault-1:0] cnt;
        logic                         seen;
    } wm_chan_state_t;

endpackage

// File: rtl/entropy_src_wm_chan.sv
// One watermark channel: high/low watermarks, saturating excursion counter, seen flag.
// Optional sticky threshold alert when ENTROPY_SRC_WM_ALERT_EN is defined.
module entropy_src_wm_chan
    import entropy_src_wm_pkg::*;
#(
    parameter int RegWidth = WmRegWidthDefault,
    parameter int CntWidth = WmCntWidthDefault
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                freeze_i,
    input  logic                event_i,
    input  logic [RegWidth-1:0] value_i,
`ifdef ENTROPY_SRC_WM_ALERT_EN
    input  logic [RegWidth-1:0] thresh_hi_i,
    input  logic [RegWidth-1:0] thresh_lo_i,
    output logic                alert_o,
`endif
    output logic [RegWidth-1:0] hi_o,
    output logic [RegWidth-1:0] lo_o,
    output logic [CntWidth-1:0] cnt_o,
    output logic                seen_o
);

    typedef struct packed {
        logic [RegWidth-1:0] hi;
        logic [RegWidth-1:0] lo;
        logic [CntWidth-1:0] cnt;
        logic                seen;
    } chan_state_t;

    localparam chan_state_t RstState = '{
        hi:   {RegWidth{1'b0}},
        lo:   {RegWidth{1'b1}},
        cnt:  {CntWidth{1'b0}},
        seen: 1'b0
    };
    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};
    localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

    chan_state_t         state_r;
    chan_state_t         state_d_s;
    logic                hi_up_s;
    logic                lo_dn_s;
    logic                accept_s;
    logic [RegWidth-1:0] hi_new_s;
    logic [RegWidth-1:0] lo_new_s;

    // Next-state: clear beats freeze, freeze beats event, otherwise hold.
    always_comb begin
        state_d_s = state_r;
        hi_up_s   = (value_i > state_r.hi);
        lo_dn_s   = (value_i < state_r.lo);
        hi_new_s  = hi_up_s ? value_i : state_r.hi;
        lo_new_s  = lo_dn_s ? value_i : state_r.lo;
        accept_s  = event_i & ~freeze_i & ~clear_i;
        if (clear_i) begin
            state_d_s = RstState;
        end else if (accept_s) begin
            state_d_s.hi   = hi_new_s;
            state_d_s.lo   = lo_new_s;
            state_d_s.seen = 1'b1;
            // Counter saturates rather than wraps so long windows stay meaningful.
            if ((hi_up_s || lo_dn_s) && (state_r.cnt != CntMax)) begin
                state_d_s.cnt = state_r.cnt + CntOne;
            end else begin
                state_d_s.cnt = state_r.cnt;
            end
        end else begin
            state_d_s = state_r;
        end
    end

    // Channel state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= RstState;
        end else begin
            state_r <= state_d_s;
        end
    end

    assign hi_o   = state_r.hi;
    assign lo_o   = state_r.lo;
    assign cnt_o  = state_r.cnt;
    assign seen_o = state_r.seen;

`ifdef ENTROPY_SRC_WM_ALERT_EN
    logic alert_r;
    logic alert_d_s;

    // Sticky alert, judged on the watermarks this event produces.
    always_comb begin
        alert_d_s = alert_r;
        if (clear_i) begin
            alert_d_s = 1'b0;
        end else if (accept_s && ((hi_new_s > thresh_hi_i) || (lo_new_s < thresh_lo_i))) begin
            alert_d_s = 1'b1;
        end else begin
            alert_d_s = alert_r;
        end
    end

    // Alert register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alert_r <= 1'b0;
        end else begin
            alert_r <= alert_d_s;
        end
    end

    assign alert_o = alert_r;
`endif

endmodule

// File: rtl/entropy_src_watermark_bank.sv
// Bank of NumCh independent watermark channels on a shared, packed sample bus.
// Define ENTROPY_SRC_WM_ALERT_EN to add shared thresholds and per-channel sticky alerts.
module entropy_src_watermark_bank
    import entropy_src_wm_pkg::*;
#(
    parameter int NumCh    = 4,
    parameter int RegWidth = WmRegWidthDefault,
    parameter int CntWidth = WmCntWidthDefault
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumCh-1:0]          clear_i,
    input  logic                      freeze_i,
    input  logic [NumCh-1:0]          event_i,
    input  logic [NumCh*RegWidth-1:0] value_i,
`ifdef ENTROPY_SRC_WM_ALERT_EN
    input  logic [RegWidth-1:0]       thresh_hi_i,
    input  logic [RegWidth-1:0]       thresh_lo_i,
    output logic [NumCh-1:0]          alert_o,
`endif
    output logic [NumCh*RegWidth-1:0] hi_wm_o,
    output logic [NumCh*RegWidth-1:0] lo_wm_o,
    output logic [NumCh*CntWidth-1:0] excur_cnt_o,
    output logic [NumCh-1:0]          seen_o
);

    for (genvar k = 0; k < NumCh; k++) begin : g_chan
        entropy_src_wm_chan #(
            .RegWidth (RegWidth),
            .CntWidth (CntWidth)
        ) u_chan (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .clear_i     (clear_i[k]),
            .freeze_i    (freeze_i),
            .event_i     (event_i[k]),
            .value_i     (value_i[k*RegWidth +: RegWidth]),
`ifdef ENTROPY_SRC_WM_ALERT_EN
            .thresh_hi_i (thresh_hi_i),
            .thresh_lo_i (thresh_lo_i),
            .alert_o     (alert_o[k]),
`endif
            .hi_o        (hi_wm_o[k*RegWidth +: RegWidth]),
            .lo_o        (lo_wm_o[k*RegWidth +: RegWidth]),
            .cnt_o       (excur_cnt_o[k*CntWidth +: CntWidth]),
            .seen_o      (seen_o[k])
        );
    end

endmodule

// File: tb/tb_entropy_src_watermark_bank.sv
// Directed self-checking bench for entropy_src_watermark_bank (NumCh=4, 16-bit samples, 8-bit counters).
// Alert checks are compiled in when ENTROPY_SRC_WM_ALERT_EN is defined.
module tb_entropy_src_watermark_bank;
    import entropy_src_wm_pkg::*;

    localparam int NumCh = 4;
    localparam int RW    = 16;
    localparam int CW    = 8;

    logic                   clk_i;
    logic                   rst_ni;
    logic [NumCh-1:0]       clear_i;
    logic                   freeze_i;
    logic [NumCh-1:0]       event_i;
    logic [NumCh*RW-1:0]    value_i;
    logic [NumCh*RW-1:0]    hi_wm_o;
    logic [NumCh*RW-1:0]    lo_wm_o;
    logic [NumCh*CW-1:0]    excur_cnt_o;
    logic [NumCh-1:0]       seen_o;
`ifdef ENTROPY_SRC_WM_ALERT_EN
    logic [RW-1:0]          thresh_hi_i;
    logic [RW-1:0]          thresh_lo_i;
    logic [NumCh-1:0]       alert_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    entropy_src_watermark_bank #(
        .NumCh    (NumCh),
        .RegWidth (RW),
        .CntWidth (CW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .freeze_i    (freeze_i),
        .event_i     (event_i),
        .value_i     (value_i),
`ifdef ENTROPY_SRC_WM_ALERT_EN
        .thresh_hi_i (thresh_hi_i),
        .thresh_lo_i (thresh_lo_i),
        .alert_o     (alert_o),
`endif
        .hi_wm_o     (hi_wm_o),
        .lo_wm_o     (lo_wm_o),
        .excur_cnt_o (excur_cnt_o),
        .seen_o      (seen_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_val(input int k, input logic [RW-1:0] v);
        value_i[k*RW +: RW] = v;
    endtask

    function automatic wm_chan_state_t mk(input logic [15:0] hi, input logic [15:0] lo,
                                          input logic [7:0] cnt, input logic seen);
        wm_chan_state_t s;
        s.hi   = hi;
        s.lo   = lo;
        s.cnt  = cnt;
        s.seen = seen;
        return s;
    endfunction

    task automatic check_chan(input string tag, input int k, input wm_chan_state_t exp);
        check($sformatf("%s ch%0d hi", tag, k),   {48'h0, hi_wm_o[k*RW +: RW]},     {48'h0, exp.hi});
        check($sformatf("%s ch%0d lo", tag, k),   {48'h0, lo_wm_o[k*RW +: RW]},     {48'h0, exp.lo});
        check($sformatf("%s ch%0d cnt", tag, k),  {56'h0, excur_cnt_o[k*CW +: CW]}, {56'h0, exp.cnt});
        check($sformatf("%s ch%0d seen", tag, k), {63'h0, seen_o[k]},               {63'h0, exp.seen});
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, " hi_all"},   hi_wm_o,             64'h0000_0000_0000_0000);
        check({tag, " lo_all"},   lo_wm_o,             64'hFFFF_FFFF_FFFF_FFFF);
        check({tag, " cnt_all"},  {32'h0, excur_cnt_o}, 64'h0);
        check({tag, " seen_all"}, {60'h0, seen_o},      64'h0);
    endtask

    initial begin
        wm_chan_state_t rst_s;
        rst_s = mk(WmHiRstDefault, WmLoRstDefault, 8'h00, 1'b0);

        rst_ni   = 1'b0;
        clear_i  = 4'b0000;
        freeze_i = 1'b0;
        event_i  = 4'b0000;
        value_i  = 64'h0;
`ifdef ENTROPY_SRC_WM_ALERT_EN
        thresh_hi_i = 16'hFFFF;
        thresh_lo_i = 16'h0000;
`endif
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        check_all_reset("reset");
`ifdef ENTROPY_SRC_WM_ALERT_EN
        check("reset alert", {60'h0, alert_o}, 64'h0);
`endif

        // Channel 0 sequence including an equal-to-hi repeat.
        event_i = 4'b0001;
        set_val(0, 16'h0100); tick();
        check_chan("seq1", 0, mk(16'h0100, 16'h0100, 8'd1, 1'b1));
        set_val(0, 16'h0050); tick();
        check_chan("seq2", 0, mk(16'h0100, 16'h0050, 8'd2, 1'b1));
        set_val(0, 16'h0200); tick();
        check_chan("seq3", 0, mk(16'h0200, 16'h0050, 8'd3, 1'b1));
        set_val(0, 16'h0200); tick();
        check_chan("seq4", 0, mk(16'h0200, 16'h0050, 8'd3, 1'b1));

        // Clear beats event on ch1; ch2 event in the same cycle.
        clear_i = 4'b0010;
        event_i = 4'b0110;
        set_val(1, 16'h1234);
        set_val(2, 16'h0007);
        tick();
        clear_i = 4'b0000;
        event_i = 4'b0000;
        check_chan("clr_vs_evt", 1, rst_s);
        check_chan("clr_vs_evt", 2, mk(16'h0007, 16'h0007, 8'd1, 1'b1));
        check_chan("clr_vs_evt", 0, mk(16'h0200, 16'h0050, 8'd3, 1'b1));

        // Freeze drops events on all channels.
        freeze_i = 1'b1;
        event_i  = 4'b1111;
        value_i  = {4{16'h9999}};
        tick();
        tick();
        check_chan("freeze", 0, mk(16'h0200, 16'h0050, 8'd3, 1'b1));
        check_chan("freeze", 1, rst_s);
        check_chan("freeze", 2, mk(16'h0007, 16'h0007, 8'd1, 1'b1));
        check_chan("freeze", 3, rst_s);
        freeze_i = 1'b0;
        tick();
        event_i = 4'b0000;
        check("unfreeze hi_all", hi_wm_o, {4{16'h9999}});
        check_chan("unfreeze", 0, mk(16'h9999, 16'h0050, 8'd4, 1'b1));
        check_chan("unfreeze", 1, mk(16'h9999, 16'h9999, 8'd1, 1'b1));
        check_chan("unfreeze", 2, mk(16'h9999, 16'h0007, 8'd2, 1'b1));
        check_chan("unfreeze", 3, mk(16'h9999, 16'h9999, 8'd1, 1'b1));

        // Ch3 saturation: every event moves one watermark outward.
        clear_i = 4'b1000;
        tick();
        clear_i = 4'b0000;
        check_chan("pre_sat", 3, rst_s);
        event_i = 4'b1000;
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) begin
                set_val(3, 16'h8000 + 16'(i));
            end else begin
                set_val(3, 16'h8000 - 16'(i));
            end
            tick();
            if (i == 253) begin
                check("sat cnt at 254", {56'h0, excur_cnt_o[3*CW +: CW]}, 64'hFE);
            end
        end
        event_i = 4'b0000;
        check_chan("sat", 3, mk(16'h812A, 16'h7ED5, 8'hFF, 1'b1));
        check_chan("sat other", 0, mk(16'h9999, 16'h0050, 8'd4, 1'b1));
        clear_i = 4'b1000;
        tick();
        clear_i = 4'b0000;
        check_chan("sat_clear", 3, rst_s);

        // Equal-to-lo on ch0 while clearing ch1/ch2, then first-event boundaries.
        clear_i = 4'b0110;
        event_i = 4'b0001;
        set_val(0, 16'h0050);
        tick();
        clear_i = 4'b0000;
        check_chan("eq_lo", 0, mk(16'h9999, 16'h0050, 8'd4, 1'b1));
        check_chan("eq_lo clr", 1, rst_s);
        event_i = 4'b0110;
        set_val(1, 16'h0000);
        set_val(2, 16'hFFFF);
        tick();
        event_i = 4'b0000;
        check_chan("first_zero", 1, mk(16'h0000, 16'h0000, 8'd1, 1'b1));
        check_chan("first_ones", 2, mk(16'hFFFF, 16'hFFFF, 8'd1, 1'b1));

        // Asynchronous reset mid-operation, with events pending.
        event_i = 4'b1111;
        value_i = {4{16'h4321}};
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_reset("async_rst");
        event_i = 4'b0000;
        tick();
        rst_ni = 1'b1;
        tick();
        check_all_reset("post_rst");

`ifdef ENTROPY_SRC_WM_ALERT_EN
        thresh_hi_i = 16'h8000;
        thresh_lo_i = 16'h0000;
        event_i = 4'b0001;
        set_val(0, 16'h8001);
        tick();
        check("alert set", {60'h0, alert_o}, 64'h1);
        set_val(0, 16'h0001);
        tick();
        event_i = 4'b0000;
        check("alert sticky", {60'h0, alert_o}, 64'h1);
        clear_i = 4'b0001;
        tick();
        clear_i = 4'b0000;
        check("alert clear", {60'h0, alert_o}, 64'h0);
        freeze_i = 1'b1;
        event_i  = 4'b0001;
        set_val(0, 16'hF000);
        tick();
        freeze_i = 1'b0;
        event_i  = 4'b0000;
        check("alert frozen", {60'h0, alert_o}, 64'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
